// File: rtl/game_round_ctrl.sv
// Round/score controller: tracks lives, hit immunity and the round timer
// from frame ticks, decides the winner and gates player movement.
module game_round_ctrl #(
    parameter int unsigned LIVES          = 3,
    parameter int unsigned INVULN_FRAMES  = 90,
    parameter int unsigned FRAMES_PER_SEC = 60,
    parameter int unsigned ROUND_SECS     = 99,
    parameter logic [7:0]  START_KEY      = 8'h28
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       collide1,
    input  logic       collide2,
    output logic [1:0] p1_lives,
    output logic [1:0] p2_lives,
    output logic [6:0] round_secs,
    output logic [1:0] state,
    output logic       play_en,
    output logic       round_rst,
    output logic [1:0] winner,
    output logic       p1_flash,
    output logic       p2_flash
);

    localparam int FW_RAW = $clog2(FRAMES_PER_SEC);
    localparam int FW     = (FW_RAW < 1) ? 1 : FW_RAW;
    // The blink uses bit 3, so the immunity counter is never narrower than 4 bits.
    localparam int IW_RAW = $clog2(INVULN_FRAMES + 1);
    localparam int IW     = (IW_RAW < 4) ? 4 : IW_RAW;

    localparam logic [1:0]    LIVES_INIT  = 2'(LIVES);
    localparam logic [6:0]    SECS_INIT   = 7'(ROUND_SECS);
    localparam logic [FW-1:0] FRAME_LAST  = FW'(FRAMES_PER_SEC - 1);
    localparam logic [IW-1:0] INVULN_INIT = IW'(INVULN_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_PLAY     = 2'b01,
        S_OVER     = 2'b10,
        S_WAIT_REL = 2'b11
    } state_t;

    logic          r_sync1, r_sync2, r_frame_prev;
    logic          w_tick;
    logic          w_start_key;

    state_t        r_state, w_state;
    logic [1:0]    r_p1_lives, w_p1_lives;
    logic [1:0]    r_p2_lives, w_p2_lives;
    logic [6:0]    r_secs, w_secs;
    logic [1:0]    r_winner, w_winner;
    logic          r_round_rst, w_round_rst;
    logic [FW-1:0] r_frame_cnt, w_frame_cnt;
    logic [IW-1:0] r_p1_inv, w_p1_inv;
    logic [IW-1:0] r_p2_inv, w_p2_inv;

    // Bring frame_clk into the Clk domain and remember its last level for edge detection.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_frame_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking so each flop takes its neighbour's pre-edge value;
            // blocking here would collapse the chain into a single stage.
            r_sync1      <= frame_clk;
            r_sync2      <= r_sync1;
            r_frame_prev <= r_sync2;
        end
    end

    assign w_tick      = r_sync2 & ~r_frame_prev;
    assign w_start_key = (keycode == START_KEY);

    // State and round bookkeeping registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_p1_lives  <= LIVES_INIT;
            r_p2_lives  <= LIVES_INIT;
            r_secs      <= SECS_INIT;
            r_winner    <= 2'b00;
            r_round_rst <= 1'b0;
            r_frame_cnt <= '0;
            r_p1_inv    <= '0;
            r_p2_inv    <= '0;
        end else begin
            r_state     <= w_state;
            r_p1_lives  <= w_p1_lives;
            r_p2_lives  <= w_p2_lives;
            r_secs      <= w_secs;
            r_winner    <= w_winner;
            r_round_rst <= w_round_rst;
            r_frame_cnt <= w_frame_cnt;
            r_p1_inv    <= w_p1_inv;
            r_p2_inv    <= w_p2_inv;
        end
    end

    // Next-state: round start, per-tick play update with end check, and key-release handshake.
    always_comb begin
        // NOTE: every signal gets its hold value first, so no path leaves one
        // unassigned and no latch is inferred.
        w_state     = r_state;
        w_p1_lives  = r_p1_lives;
        w_p2_lives  = r_p2_lives;
        w_secs      = r_secs;
        w_winner    = r_winner;
        w_round_rst = 1'b0;
        w_frame_cnt = r_frame_cnt;
        w_p1_inv    = r_p1_inv;
        w_p2_inv    = r_p2_inv;

        case (r_state)
            S_IDLE, S_WAIT_REL: begin
                if (w_start_key) begin
                    w_p1_lives  = LIVES_INIT;
                    w_p2_lives  = LIVES_INIT;
                    w_secs      = SECS_INIT;
                    w_frame_cnt = '0;
                    w_p1_inv    = '0;
                    w_p2_inv    = '0;
                    w_winner    = 2'b00;
                    w_round_rst = 1'b1;
                    w_state     = S_PLAY;
                end
            end

            S_PLAY: begin
                if (w_tick) begin
                    if (r_frame_cnt == FRAME_LAST) begin
                        w_frame_cnt = '0;
                        if (r_secs != 7'd0) w_secs = r_secs - 7'd1;
                    end else begin
                        w_frame_cnt = r_frame_cnt + FW'(1);
                    end

                    if (r_p1_inv != '0) begin
                        w_p1_inv = r_p1_inv - IW'(1);
                    end else if (collide1 && (r_p1_lives != 2'd0)) begin
                        w_p1_lives = r_p1_lives - 2'd1;
                        w_p1_inv   = INVULN_INIT;
                    end

                    if (r_p2_inv != '0) begin
                        w_p2_inv = r_p2_inv - IW'(1);
                    end else if (collide2 && (r_p2_lives != 2'd0)) begin
                        w_p2_lives = r_p2_lives - 2'd1;
                        w_p2_inv   = INVULN_INIT;
                    end

                    // Decide on the values this tick produces, not the stale ones.
                    if ((w_p1_lives == 2'd0) && (w_p2_lives == 2'd0)) begin
                        w_winner = 2'b11;
                        w_state  = S_OVER;
                    end else if (w_p1_lives == 2'd0) begin
                        w_winner = 2'b10;
                        w_state  = S_OVER;
                    end else if (w_p2_lives == 2'd0) begin
                        w_winner = 2'b01;
                        w_state  = S_OVER;
                    end else if (w_secs == 7'd0) begin
                        if (w_p1_lives > w_p2_lives)      w_winner = 2'b01;
                        else if (w_p2_lives > w_p1_lives) w_winner = 2'b10;
                        else                              w_winner = 2'b11;
                        w_state = S_OVER;
                    end
                end
            end

            S_OVER: begin
                // Wait for the start key to be let go so a held key cannot restart at once.
                if (!w_start_key) w_state = S_WAIT_REL;
            end

            default: w_state = S_IDLE;
        endcase
    end

    assign p1_lives   = r_p1_lives;
    assign p2_lives   = r_p2_lives;
    assign round_secs = r_secs;
    assign state      = r_state;
    assign play_en    = (r_state == S_PLAY);
    assign round_rst  = r_round_rst;
    assign winner     = r_winner;
    assign p1_flash   = (r_p1_inv != '0) & r_p1_inv[3];
    assign p2_flash   = (r_p2_inv != '0) & r_p2_inv[3];

endmodule
